// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_pkg
// Description : Shared types and constants for the crossroad traffic light
//               controller: phase enum, lamp encodings, countdown width and
//               small helpers for phase sequencing and lamp lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;

  localparam int CNT_W = 8;

  // Lamp sets are {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [1:0] {
    NS_GREEN  = 2'd0,
    NS_YELLOW = 2'd1,
    EW_GREEN  = 2'd2,
    EW_YELLOW = 2'd3
  } tl_state_e;

  function automatic tl_state_e next_phase(input tl_state_e s);
    tl_state_e n;
    n = NS_GREEN;
    case (s)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = NS_GREEN;
      default:   n = NS_GREEN;
    endcase
    return n;
  endfunction

  function automatic logic is_green(input tl_state_e s);
    return (s == NS_GREEN) || (s == EW_GREEN);
  endfunction

  function automatic logic [2:0] ns_lamp(input tl_state_e s);
    logic [2:0] l;
    l = LAMP_RED;
    case (s)
      NS_GREEN:  l = LAMP_GRN;
      NS_YELLOW: l = LAMP_YEL;
      default:   l = LAMP_RED;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] ew_lamp(input tl_state_e s);
    logic [2:0] l;
    l = LAMP_RED;
    case (s)
      EW_GREEN:  l = LAMP_GRN;
      EW_YELLOW: l = LAMP_YEL;
      default:   l = LAMP_RED;
    endcase
    return l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_sec_tick.sv
`default_nettype none
// ============================================================================
// Module      : tl_sec_tick
// Description : Free-running 1 s timebase. Counts 0..CLK_FREQ-1 and wraps;
//               sec_tick is high for the single cycle the count sits at
//               CLK_FREQ-1. clr restarts the count at 0 on the next edge.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               clr      - synchronous restart of the count
//               sec_tick - one-cycle pulse once per second
// Revision    : 1.0 - initial release
// ============================================================================
module tl_sec_tick #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic sec_tick
);

  localparam int         W      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [W-1:0] C_LAST = W'(CLK_FREQ - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign sec_tick = (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || sec_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tl_ctrl
// Description : Crossroad traffic light phase controller. Cycles
//               NS_GREEN -> NS_YELLOW -> EW_GREEN -> EW_YELLOW, counting each
//               phase down in seconds. A pedestrian request shortens the
//               current green, or the next green if it arrives during yellow.
//               Optional night mode (macro TL_NIGHT_MODE_EN) freezes the
//               phase machine and flashes yellow on both approaches.
// Ports       : clk         - system clock
//               rst_n       - asynchronous active-low reset
//               key_flag    - debounced pedestrian request pulse
//               night_flag  - debounced night-mode toggle pulse (only used
//                             with TL_NIGHT_MODE_EN)
//               ns_light    - north-south {red,yellow,green}, registered
//               ew_light    - east-west {red,yellow,green}, registered
//               countdown   - seconds left in current phase, registered
//               req_pending - request latched during yellow
// Revision    : 1.0 - initial release
// ============================================================================
module tl_ctrl
  import tl_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int GREEN_S  = 30,
  parameter int YELLOW_S = 3,
  parameter int SHORT_S  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_flag,
  input  logic             night_flag,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] countdown,
  output logic             req_pending
);

  localparam logic [CNT_W-1:0] C_GREEN  = CNT_W'(GREEN_S);
  localparam logic [CNT_W-1:0] C_YELLOW = CNT_W'(YELLOW_S);
  localparam logic [CNT_W-1:0] C_SHORT  = CNT_W'(SHORT_S);

  tl_state_e        state_q, state_d;
  logic [CNT_W-1:0] cd_q, cd_d;
  logic             req_q, req_d;
  logic [2:0]       ns_q, ns_d;
  logic [2:0]       ew_q, ew_d;
  logic             sec_tick;
  logic             tick_clr;

  tl_sec_tick #(
    .CLK_FREQ (CLK_FREQ)
  ) u_sec_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tick_clr),
    .sec_tick (sec_tick)
  );

`ifdef TL_NIGHT_MODE_EN
  logic night_q, night_d;
  logic blink_q, blink_d;
`else
  logic w_unused_night;
  assign w_unused_night = night_flag;
`endif

  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    req_d    = req_q;
    tick_clr = 1'b0;
`ifdef TL_NIGHT_MODE_EN
    night_d  = night_q;
    blink_d  = blink_q;

    // night_flag is checked first so a coincident key_flag is dropped
    if (night_flag) begin
      if (!night_q) begin
        night_d = 1'b1;
        blink_d = 1'b1;
        cd_d    = '0;
        req_d   = 1'b0;
      end else begin
        // Leave night mode with a fresh phase and a full first second
        night_d  = 1'b0;
        state_d  = NS_GREEN;
        cd_d     = C_GREEN;
        tick_clr = 1'b1;
      end
    end else if (night_q) begin
      if (sec_tick) begin
        blink_d = ~blink_q;
      end
    end else
`endif
    begin
      if (sec_tick && (cd_q == CNT_W'(1))) begin
        // Phase boundary wins over any key. A key arriving in yellow on
        // this same edge still earns the next green the short length.
        state_d = next_phase(state_q);
        if (is_green(state_q)) begin
          cd_d = C_YELLOW;
        end else if (req_q || key_flag) begin
          cd_d = C_SHORT;
        end else begin
          cd_d = C_GREEN;
        end
        req_d = 1'b0;
      end else begin
        if (sec_tick) begin
          cd_d = cd_q - CNT_W'(1);
        end
        if (key_flag) begin
          if (is_green(state_q)) begin
            // Overrides the decrement of a coincident tick
            if (cd_q > C_SHORT) begin
              cd_d = C_SHORT;
            end
          end else begin
            req_d = 1'b1;
          end
        end
      end
    end

    // Lamps are derived from the next state so they change on the same
    // edge as the phase itself.
    ns_d = ns_lamp(state_d);
    ew_d = ew_lamp(state_d);
`ifdef TL_NIGHT_MODE_EN
    if (night_d) begin
      ns_d = blink_d ? LAMP_YEL : LAMP_OFF;
      ew_d = blink_d ? LAMP_YEL : LAMP_OFF;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NS_GREEN;
      cd_q    <= C_GREEN;
      req_q   <= 1'b0;
      ns_q    <= LAMP_GRN;
      ew_q    <= LAMP_RED;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      req_q   <= req_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
    end
  end

`ifdef TL_NIGHT_MODE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      night_q <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      night_q <= night_d;
      blink_q <= blink_d;
    end
  end
`endif

  assign ns_light    = ns_q;
  assign ew_light    = ew_q;
  assign countdown   = cd_q;
  assign req_pending = req_q;

endmodule
`default_nettype wire

// File: tb/tb_tl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_ctrl
// Description : Self-checking bench for tl_ctrl (CLK_FREQ=10, GREEN_S=6,
//               YELLOW_S=2, SHORT_S=3). A behavioural phase model predicts
//               the outputs after every clock; predictions are queued when
//               inputs are driven and compared after the edge. Directed
//               checks pin the key timing corner cases and async reset.
//               Night-mode checks are active with TL_NIGHT_MODE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_ctrl;

  localparam int CLK_FREQ = 10;
  localparam int GREEN_S  = 6;
  localparam int YELLOW_S = 2;
  localparam int SHORT_S  = 3;

  logic       clk;
  logic       rst_n;
  logic       key_flag;
  logic       night_flag;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [7:0] countdown;
  logic       req_pending;

  tl_ctrl #(
    .CLK_FREQ (CLK_FREQ),
    .GREEN_S  (GREEN_S),
    .YELLOW_S (YELLOW_S),
    .SHORT_S  (SHORT_S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_flag    (key_flag),
    .night_flag  (night_flag),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .countdown   (countdown),
    .req_pending (req_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [14:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 NS green, 1 NS yellow, 2 EW green, 3 EW yellow
  int m_t, m_ph, m_cd;
  bit m_req, m_night, m_blink;

  function automatic void mdl_reset();
    m_t = 0; m_ph = 0; m_cd = GREEN_S; m_req = 0; m_night = 0; m_blink = 0;
  endfunction

  function automatic logic [2:0] ns_of(input int ph);
    case (ph)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] ew_of(input int ph);
    case (ph)
      2:       return 3'b001;
      3:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [14:0] mdl_vec();
    logic [2:0] ns, ew;
    ns = ns_of(m_ph);
    ew = ew_of(m_ph);
    if (m_night) begin
      ns = m_blink ? 3'b010 : 3'b000;
      ew = ns;
    end
    return {ns, ew, 8'(m_cd), m_req};
  endfunction

  function automatic void mdl_step(input bit key, input bit nf);
    bit tk, clr, done;
    tk   = (m_t == CLK_FREQ - 1);
    clr  = 0;
    done = 0;
`ifdef TL_NIGHT_MODE_EN
    if (nf) begin
      done = 1;
      if (!m_night) begin
        m_night = 1; m_blink = 1; m_cd = 0; m_req = 0;
      end else begin
        m_night = 0; m_ph = 0; m_cd = GREEN_S; clr = 1;
      end
    end else if (m_night) begin
      done = 1;
      if (tk) m_blink = !m_blink;
    end
`else
    done = nf & 1'b0;
`endif
    if (!done) begin
      bit grn;
      grn = (m_ph == 0) || (m_ph == 2);
      if (tk && m_cd == 1) begin
        if (grn)                m_cd = YELLOW_S;
        else if (m_req || key)  m_cd = SHORT_S;
        else                    m_cd = GREEN_S;
        m_ph  = (m_ph + 1) % 4;
        m_req = 0;
      end else if (key && grn) begin
        if (m_cd > SHORT_S) m_cd = SHORT_S;
        else if (tk)        m_cd = m_cd - 1;
      end else begin
        if (tk)  m_cd = m_cd - 1;
        if (key) m_req = 1;
      end
    end
    m_t = clr ? 0 : (m_t + 1) % CLK_FREQ;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit key, input bit nf);
    logic [14:0] exp;
    key_flag   = key;
    night_flag = nf;
    mdl_step(key, nf);
    sb_q.push_back(mdl_vec());
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check("sb", 32'({ns_light, ew_light, countdown, req_pending}), 32'(exp));
    end
    key_flag   = 1'b0;
    night_flag = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step(1'b0, 1'b0);
  endtask

  task automatic check_out(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                           input logic [7:0] cd, input logic req);
    check({tag, "_ns"},  32'(ns_light),    32'(ns));
    check({tag, "_ew"},  32'(ew_light),    32'(ew));
    check({tag, "_cd"},  32'(countdown),   32'(cd));
    check({tag, "_req"}, 32'(req_pending), 32'(req));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    key_flag   = 1'b0;
    night_flag = 1'b0;
    mdl_reset();
    repeat (3) @(posedge clk);
    #2;
    check_out("reset", 3'b001, 3'b100, 8'd6, 1'b0);
    release_reset();

    // Free-running cycle without requests
    run_to(9);   check("cd_first_sec", 32'(countdown), 32'd6);
    run_to(10);  check("cd_after_tick", 32'(countdown), 32'd5);
    run_to(60);  check_out("ns_yellow", 3'b010, 3'b100, 8'd2, 1'b0);
    run_to(80);  check_out("ew_green", 3'b100, 3'b001, 8'd6, 1'b0);
    run_to(160); check_out("full_cycle", 3'b001, 3'b100, 8'd6, 1'b0);

    // Key at green countdown 6 shortens to SHORT_S
    step(1'b1, 1'b0); check_out("key_short", 3'b001, 3'b100, 8'd3, 1'b0);
    run_to(190);      check_out("short_end", 3'b010, 3'b100, 8'd2, 1'b0);

    // Key in yellow is latched and shortens the next green
    step(1'b1, 1'b0); check("yel_req", 32'(req_pending), 32'd1);
    run_to(195);
    step(1'b1, 1'b0); check("yel_req2", 32'(req_pending), 32'd1);
    run_to(210);      check_out("req_green", 3'b100, 3'b001, 8'd3, 1'b0);

    // Key at countdown 2 in green is ignored
    run_to(220);
    step(1'b1, 1'b0); check_out("key_ignored", 3'b100, 3'b001, 8'd2, 1'b0);

    // Key coincident with tick at EW green countdown 5 -> SHORT_S, not 4
    run_to(359);      check("pre_coinc_cd", 32'(countdown), 32'd5);
    step(1'b1, 1'b0); check("coinc_cd", 32'(countdown), 32'd3);

    // Key with tick at countdown 1 in yellow -> next green short
    run_to(409);
    step(1'b1, 1'b0); check_out("yel_edge_key", 3'b001, 3'b100, 8'd3, 1'b0);

    // Key with tick at countdown 1 in green -> normal advance
    run_to(439);
    step(1'b1, 1'b0); check_out("grn_edge_key", 3'b010, 3'b100, 8'd2, 1'b0);

    // Async reset in EW yellow
    run_to(520);      check("in_ew_yellow", 32'(ew_light), 32'b010);
    run_to(525);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 3'b001, 3'b100, 8'd6, 1'b0);
    mdl_reset();
    release_reset();

    // Random requests against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 5) == 0), 1'b0);
    end

`ifdef TL_NIGHT_MODE_EN
    step(1'b0, 1'b1); check_out("night_in", 3'b010, 3'b010, 8'd0, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0); check("night_key_cd", 32'(countdown), 32'd0);
    step(1'b1, 1'b1); check_out("night_out", 3'b001, 3'b100, 8'd6, 1'b0);
    for (int i = 0; i < 80; i++) step(1'b0, 1'b0);
`else
    // Without night mode the toggle input has no effect
    step(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
